// File: rtl/mdu_pkg.sv
// Shared op encodings, FSM state type and latency constants for the E_MDU multiply/divide unit.
package mdu_pkg;

   localparam logic [3:0] OP_NONE  = 4'd0;
   localparam logic [3:0] OP_MULT  = 4'd1;
   localparam logic [3:0] OP_MULTU = 4'd2;
   localparam logic [3:0] OP_DIV   = 4'd3;
   localparam logic [3:0] OP_DIVU  = 4'd4;
   localparam logic [3:0] OP_MFHI  = 4'd5;
   localparam logic [3:0] OP_MFLO  = 4'd6;
   localparam logic [3:0] OP_MTHI  = 4'd7;
   localparam logic [3:0] OP_MTLO  = 4'd8;

   localparam logic [3:0] MULT_CYCLES = 4'd5;
   localparam logic [3:0] DIV_CYCLES  = 4'd10;

   typedef enum logic {StIdle, StRun} mdu_state_e;

endpackage

// File: rtl/e_mdu_calc.sv
// Combinational product/quotient/remainder for E_MDU.
// Divider logic is only built when MDU_DIV_EN is defined.
module e_mdu_calc
   import mdu_pkg::*;
(
   input  logic [3:0]  op,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic [31:0] hi,
   output logic [31:0] lo,
   output logic        wr
);

   logic [63:0] prod_s;
   logic [63:0] prod_u;

   assign prod_s = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
   assign prod_u = {32'd0, a} * {32'd0, b};

`ifdef MDU_DIV_EN
   logic        neg_a;
   logic        neg_b;
   logic [31:0] ua;
   logic [31:0] ub;
   logic [31:0] ub_safe;
   logic [31:0] qu;
   logic [31:0] ru;
   logic [31:0] quo;
   logic [31:0] rem;

   // Sign-magnitude division: 0x80000000 / -1 falls out as 0x80000000 rem 0 without overflow.
   assign neg_a   = (op == OP_DIV) & a[31];
   assign neg_b   = (op == OP_DIV) & b[31];
   assign ua      = neg_a ? -a : a;
   assign ub      = neg_b ? -b : b;
   assign ub_safe = (ub == 32'd0) ? 32'd1 : ub;
   assign qu      = ua / ub_safe;
   assign ru      = ua % ub_safe;
   assign quo     = (neg_a ^ neg_b) ? -qu : qu;
   assign rem     = neg_a ? -ru : ru;
`endif

   always_comb begin
      hi = 32'd0;
      lo = 32'd0;
      wr = 1'b0;
      case (op)
         OP_MULT: begin
            {hi, lo} = prod_s;
            wr       = 1'b1;
         end
         OP_MULTU: begin
            {hi, lo} = prod_u;
            wr       = 1'b1;
         end
`ifdef MDU_DIV_EN
         OP_DIV, OP_DIVU: begin
            if (b != 32'd0) begin
               hi = rem;
               lo = quo;
               wr = 1'b1;
            end
         end
`endif
         default: ;
      endcase
   end

endmodule

// File: rtl/e_mdu.sv
// Multicycle MIPS-style multiply/divide unit with HI/LO registers.
// Define MDU_DIV_EN to enable div/divu; otherwise ops 3/4 behave as no-ops.
module e_mdu
   import mdu_pkg::*;
(
   input  logic        clk,
   input  logic        reset_n,
   input  logic [31:0] MDUIn1,
   input  logic [31:0] MDUIn2,
   input  logic [3:0]  MDUOp,
   input  logic        Start,
   output logic        Busy,
   output logic [31:0] MDURes
);

   mdu_state_e  state;
   logic [31:0] hi;
   logic [31:0] lo;
   logic [3:0]  cnt;
   logic [3:0]  op_q;
   logic [31:0] a_q;
   logic [31:0] b_q;

   logic        is_mul;
   logic        is_div;
   logic [31:0] calc_hi;
   logic [31:0] calc_lo;
   logic        calc_wr;

   assign is_mul = (MDUOp == OP_MULT) || (MDUOp == OP_MULTU);
`ifdef MDU_DIV_EN
   assign is_div = (MDUOp == OP_DIV) || (MDUOp == OP_DIVU);
`else
   assign is_div = 1'b0;
`endif

   e_mdu_calc u_calc (
      .op (op_q),
      .a  (a_q),
      .b  (b_q),
      .hi (calc_hi),
      .lo (calc_lo),
      .wr (calc_wr)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= StIdle;
         hi    <= 32'd0;
         lo    <= 32'd0;
         cnt   <= 4'd0;
         op_q  <= OP_NONE;
         a_q   <= 32'd0;
         b_q   <= 32'd0;
      end else begin
         case (state)
            StIdle: begin
               if (Start && (is_mul || is_div)) begin
                  op_q  <= MDUOp;
                  a_q   <= MDUIn1;
                  b_q   <= MDUIn2;
                  cnt   <= is_mul ? MULT_CYCLES : DIV_CYCLES;
                  state <= StRun;
               end
               if (MDUOp == OP_MTHI) hi <= MDUIn1;
               if (MDUOp == OP_MTLO) lo <= MDUIn1;
            end
            StRun: begin
               cnt <= cnt - 4'd1;
               if (cnt == 4'd1) begin
                  // Zero divisor leaves calc_wr low, so HI/LO keep their old values.
                  if (calc_wr) begin
                     hi <= calc_hi;
                     lo <= calc_lo;
                  end
                  state <= StIdle;
               end
            end
         endcase
      end
   end

   assign Busy = (state == StRun);

   always_comb begin
      MDURes = 32'd0;
      if (MDUOp == OP_MFHI) MDURes = hi;
      else if (MDUOp == OP_MFLO) MDURes = lo;
   end

endmodule

// File: tb/tb_e_mdu.sv
// Directed self-checking bench for e_mdu; div tests follow the MDU_DIV_EN build option.
module tb_e_mdu;

   logic        clk;
   logic        reset_n;
   logic [31:0] MDUIn1;
   logic [31:0] MDUIn2;
   logic [3:0]  MDUOp;
   logic        Start;
   logic        Busy;
   logic [31:0] MDURes;

   int checks;
   int errors;
   int cyc;
   logic busy0;

   e_mdu dut (
      .clk     (clk),
      .reset_n (reset_n),
      .MDUIn1  (MDUIn1),
      .MDUIn2  (MDUIn2),
      .MDUOp   (MDUOp),
      .Start   (Start),
      .Busy    (Busy),
      .MDURes  (MDURes)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Read HI and LO through MDURes while idle; leaves MDUOp at none.
   task automatic chk_hilo(input string tag, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
      MDUOp = 4'd5;
      #1;
      chk({tag, "_hi"}, MDURes, exp_hi);
      MDUOp = 4'd6;
      #1;
      chk({tag, "_lo"}, MDURes, exp_lo);
      MDUOp = 4'd0;
      #1;
   endtask

   task automatic write_hilo(input logic [31:0] h, input logic [31:0] l);
      MDUOp = 4'd7; MDUIn1 = h; tick();
      MDUOp = 4'd8; MDUIn1 = l; tick();
      MDUOp = 4'd0;
   endtask

   // Pulse Start with op/a/b, then count edges until Busy falls (bounded).
   // At busy cycle inj_cyc, drive inj_op/inj_start/inj_val for one cycle as interference.
   task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input int inj_cyc, input logic [3:0] inj_op, input logic inj_start,
                         input logic [31:0] inj_val, output logic b0, output int cycles);
      MDUOp = op; MDUIn1 = a; MDUIn2 = b; Start = 1'b1;
      tick();
      Start = 1'b0; MDUOp = 4'd0;
      b0 = Busy;
      cycles = 0;
      while (Busy && cycles < 40) begin
         if (cycles == inj_cyc) begin
            MDUOp = inj_op; Start = inj_start; MDUIn1 = inj_val; MDUIn2 = inj_val;
         end else begin
            MDUOp = 4'd0; Start = 1'b0;
         end
         tick();
         cycles++;
      end
      MDUOp = 4'd0; Start = 1'b0;
   endtask

   initial begin
      checks = 0; errors = 0;
      reset_n = 1'b0; MDUIn1 = 32'd0; MDUIn2 = 32'd0; MDUOp = 4'd0; Start = 1'b0;
      repeat (2) tick();
      chk("reset_busy", {31'd0, Busy}, 32'd0);
      chk_hilo("reset", 32'd0, 32'd0);

      // Start on the very first edge after reset release.
      reset_n = 1'b1;
      run_op(4'd1, 32'hFFFF_FFFF, 32'd2, -1, 4'd0, 1'b0, 32'd0, busy0, cyc);
      chk("mult_busy0", {31'd0, busy0}, 32'd1);
      chk("mult_cycles", cyc, 32'd5);
      chk_hilo("mult", 32'hFFFF_FFFF, 32'hFFFF_FFFE);

      run_op(4'd2, 32'hFFFF_FFFF, 32'd2, -1, 4'd0, 1'b0, 32'd0, busy0, cyc);
      chk("multu_cycles", cyc, 32'd5);
      chk_hilo("multu", 32'h0000_0001, 32'hFFFF_FFFE);

      write_hilo(32'h1234_5678, 32'hCAFE_BABE);
      chk_hilo("mthi_mtlo", 32'h1234_5678, 32'hCAFE_BABE);

      // Start with an op outside 1-4 must not launch anything.
      MDUOp = 4'd9; Start = 1'b1; MDUIn1 = 32'd3; MDUIn2 = 32'd3;
      tick();
      Start = 1'b0; MDUOp = 4'd0;
      chk("bad_op_busy", {31'd0, Busy}, 32'd0);
      chk_hilo("bad_op", 32'h1234_5678, 32'hCAFE_BABE);

      // mtlo while busy is ignored; LO ends with the product only.
      run_op(4'd1, 32'd3, 32'd4, 1, 4'd8, 1'b0, 32'hDEAD_BEEF, busy0, cyc);
      chk("mtlo_busy_cycles", cyc, 32'd5);
      chk_hilo("mtlo_busy", 32'd0, 32'd12);

      // Second Start during RUN (with changed operands) is ignored.
      run_op(4'd1, 32'd5, 32'd6, 2, 4'd2, 1'b1, 32'hFFFF_FFFF, busy0, cyc);
      chk("restart_cycles", cyc, 32'd5);
      tick();
      chk("restart_idle", {31'd0, Busy}, 32'd0);
      chk_hilo("restart", 32'd0, 32'd30);

`ifdef MDU_DIV_EN
      run_op(4'd3, 32'hFFFF_FFF9, 32'd2, -1, 4'd0, 1'b0, 32'd0, busy0, cyc);
      chk("div_cycles", cyc, 32'd10);
      chk_hilo("div", 32'hFFFF_FFFF, 32'hFFFF_FFFD);

      run_op(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, -1, 4'd0, 1'b0, 32'd0, busy0, cyc);
      chk_hilo("div_ovf", 32'd0, 32'h8000_0000);

      run_op(4'd4, 32'hFFFF_FFF9, 32'd2, -1, 4'd0, 1'b0, 32'd0, busy0, cyc);
      chk_hilo("divu", 32'd1, 32'h7FFF_FFFC);

      write_hilo(32'hAAAA_5555, 32'h5555_AAAA);
      run_op(4'd4, 32'd7, 32'd0, -1, 4'd0, 1'b0, 32'd0, busy0, cyc);
      chk("divu0_cycles", cyc, 32'd10);
      chk_hilo("divu0", 32'hAAAA_5555, 32'h5555_AAAA);
`else
      write_hilo(32'hAAAA_5555, 32'h5555_AAAA);
      run_op(4'd3, 32'hFFFF_FFF9, 32'd2, -1, 4'd0, 1'b0, 32'd0, busy0, cyc);
      chk("nodiv_busy0", {31'd0, busy0}, 32'd0);
      chk("nodiv_cycles", cyc, 32'd0);
      chk_hilo("nodiv", 32'hAAAA_5555, 32'h5555_AAAA);
`endif

      // Reset in the middle of a mult aborts it with no later HI/LO write.
      write_hilo(32'h0BAD_F00D, 32'h0000_1111);
      MDUOp = 4'd1; MDUIn1 = 32'd3; MDUIn2 = 32'd4; Start = 1'b1;
      tick();
      Start = 1'b0; MDUOp = 4'd0;
      tick();
      tick();
      #2 reset_n = 1'b0;
      #1;
      chk("rst_abort_busy", {31'd0, Busy}, 32'd0);
      chk_hilo("rst_abort", 32'd0, 32'd0);
      tick();
      reset_n = 1'b1;
      repeat (8) tick();
      chk("rst_after_busy", {31'd0, Busy}, 32'd0);
      chk_hilo("rst_after", 32'd0, 32'd0);

      run_op(4'd1, 32'd7, 32'hFFFF_FFFD, -1, 4'd0, 1'b0, 32'd0, busy0, cyc);
      chk("mult_neg_cycles", cyc, 32'd5);
      chk_hilo("mult_neg", 32'hFFFF_FFFF, 32'hFFFF_FFEB);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/e_mdu.md
E_MDU -- requirements
Module: E_MDU

Interface
REQ-001 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-002 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-003 SHALL have port MDUIn1, input, 32, rs operand.
REQ-004 SHALL have port MDUIn2, input, 32, rt operand.
REQ-005 SHALL have port MDUOp, input, 4: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mfhi, 6 mflo, 7 mthi, 8 mtlo; 9-15 none.
REQ-006 SHALL have port Start, input, 1, one-cycle pulse qualifying ops 1-4.
REQ-007 SHALL have port Busy, output, 1, high while an operation is in flight.
REQ-008 SHALL have port MDURes, output, 32, read data for mfhi/mflo.

Function
REQ-009 SHALL hold state IDLE or RUN, plus 32-bit HI, 32-bit LO, 4-bit cycle counter, latched op and operands.
REQ-010 SHALL, in IDLE with Start=1 and MDUOp 1-4, latch op and operands, load counter (mult/multu 5, div/divu 10), enter RUN.
REQ-011 SHALL assert Busy from the cycle after Start until the edge on which HI/LO are written; Busy low in IDLE.
REQ-012 SHALL decrement counter each RUN cycle; at count 1, write HI/LO and return to IDLE on that edge.
REQ-013 SHALL compute mult as signed 32x32->64 and multu as unsigned, {HI,LO} = product.
REQ-014 SHALL compute div/divu as LO = quotient, HI = remainder, truncation toward zero, remainder sign follows dividend.
REQ-015 SHALL leave HI and LO unchanged when the latched divisor is zero.
REQ-016 SHALL compute results from latched operands only; input changes during RUN have no effect.
REQ-017 SHALL ignore Start and all MDUOp values while Busy=1 (upstream stalls the pipeline).
REQ-018 SHALL ignore Start with MDUOp outside 1-4.
REQ-019 SHALL, in IDLE, write HI <= MDUIn1 for mthi and LO <= MDUIn1 for mtlo on the next edge, independent of Start.
REQ-020 SHALL drive MDURes combinationally: HI for mfhi, LO for mflo, else 32'h00000000.
REQ-021 SHALL keep the 0x80000000 / -1 signed div defined: LO = 0x80000000, HI = 0.

Reset
REQ-022 SHALL on reset_n low immediately clear HI, LO, counter and latched fields, force IDLE and Busy=0, aborting any operation with no HI/LO write.
REQ-023 SHALL accept a new Start on the first edge after reset_n deasserts.

Configuration
REQ-024 SHALL use macro MDU_DIV_EN: defined -> div/divu per REQ-010/014; undefined -> ops 3/4 treated as none (no Busy, HI/LO unchanged) and divider logic absent.

Structure
REQ-025 SHALL place op encodings, MULT_CYCLES=5, DIV_CYCLES=10 in shared package mdu_pkg.
REQ-026 SHALL isolate the combinational product/quotient/remainder logic in one sub-module E_MDU_Calc; state and counter stay in E_MDU.

Verification
REQ-027 SHALL check mult 0xFFFFFFFF x 2 with Start -> Busy 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFE; multu same -> HI=0x00000001, LO=0xFFFFFFFE.
REQ-028 SHALL check div -7 / 2 -> Busy 10 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF; divu 7 / 0 -> HI/LO unchanged.
REQ-029 SHALL check mthi 0x12345678 then mfhi -> MDURes=0x12345678; mtlo during Busy -> LO not written.
REQ-030 SHALL check second Start during RUN -> ignored, result of first op only, Busy length unchanged.
REQ-031 SHALL check reset_n pulled low at cycle 3 of mult -> Busy=0 at once, HI=LO=0, no later write.
REQ-032 SHALL check build without MDU_DIV_EN: div Start -> Busy stays 0, HI/LO unchanged.
